// File: rtl/id_stall_ctrl_if.sv
// Handshake bundle between the ID/EX pipeline glue and the interlock controller.
// The *_slot_o vectors expose the shadow slots as {valid, we, waddr[4:0], is_load, is_mdu}.
interface id_stall_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             id_valid_i;
  logic             id_re1_i;
  logic             id_re2_i;
  logic [4:0]       id_raddr1_i;
  logic [4:0]       id_raddr2_i;
  logic             id_we_i;
  logic [4:0]       id_waddr_i;
  logic             id_is_load_i;
  logic             id_is_mdu_i;
  logic             mem_ack_i;
  logic             mdu_done_i;
  logic             flush_i;
  logic             stall_o;
  logic             bubble_o;
  logic             ex_hold_o;
  logic             mem_hold_o;
  logic [1:0]       cause_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [8:0]       ex_slot_o;
  logic [8:0]       mem_slot_o;
  logic [8:0]       wb_slot_o;

  modport master (
    output id_valid_i, id_re1_i, id_re2_i, id_raddr1_i, id_raddr2_i,
           id_we_i, id_waddr_i, id_is_load_i, id_is_mdu_i,
           mem_ack_i, mdu_done_i, flush_i,
    input  stall_o, bubble_o, ex_hold_o, mem_hold_o, cause_o, stall_cnt_o,
           ex_slot_o, mem_slot_o, wb_slot_o
  );

  modport slave (
    input  id_valid_i, id_re1_i, id_re2_i, id_raddr1_i, id_raddr2_i,
           id_we_i, id_waddr_i, id_is_load_i, id_is_mdu_i,
           mem_ack_i, mdu_done_i, flush_i,
    output stall_o, bubble_o, ex_hold_o, mem_hold_o, cause_o, stall_cnt_o,
           ex_slot_o, mem_slot_o, wb_slot_o
  );
endinterface

// File: rtl/id_stall_ctrl.sv
// Pipeline interlock: tracks in-flight writes in EX/MEM/WB and stalls ID on
// hazards the operand bypass cannot cover (EX result, pending load, busy MDU).
module id_stall_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  id_stall_ctrl_if.slave bus
);

  typedef struct packed {
    logic       valid;
    logic       we;
    logic [4:0] waddr;
    logic       is_load;
    logic       is_mdu;
  } slot_t;

  slot_t            ex_q, ex_d;
  slot_t            mem_q, mem_d;
  slot_t            wb_q, wb_d;
  slot_t            id_rec;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic       mem_hold;
  logic       ex_hold;
  logic       raw;
  logic       stall;
  logic [1:0] cause;

  logic       op_re    [2];
  logic [4:0] op_raddr [2];
  logic [1:0] op_hit;

  assign op_re[0]    = bus.id_re1_i;
  assign op_re[1]    = bus.id_re2_i;
  assign op_raddr[0] = bus.id_raddr1_i;
  assign op_raddr[1] = bus.id_raddr2_i;

  // Only the EX producer interlocks; MEM/WB results reach ID through the bypass.
  for (genvar gi = 0; gi < 2; gi++) begin : g_op
    assign op_hit[gi] = op_re[gi] && (op_raddr[gi] != 5'd0) &&
                        ex_q.valid && ex_q.we && (ex_q.waddr == op_raddr[gi]);
  end

  always_comb begin
    mem_hold = mem_q.valid && mem_q.is_load && !bus.mem_ack_i;
    ex_hold  = ex_q.valid && ex_q.is_mdu && !bus.mdu_done_i && !mem_hold;
    raw      = bus.id_valid_i && !mem_hold && !ex_hold && (|op_hit);
    stall    = mem_hold || ex_hold || raw;
    if (mem_hold)     cause = 2'd3;
    else if (ex_hold) cause = 2'd2;
    else if (raw)     cause = 2'd1;
    else              cause = 2'd0;
  end

  always_comb begin
    id_rec.valid   = bus.id_valid_i && !bus.flush_i;
    id_rec.we      = bus.id_we_i;
    id_rec.waddr   = bus.id_waddr_i;
    id_rec.is_load = bus.id_is_load_i;
    id_rec.is_mdu  = bus.id_is_mdu_i;

    ex_d  = id_rec;
    mem_d = ex_q;
    wb_d  = mem_q;
    // A hold freezes every stage up to the blocked one and bubbles the next.
    if (mem_hold) begin
      ex_d  = ex_q;
      mem_d = mem_q;
      wb_d  = '0;
    end else if (ex_hold) begin
      ex_d  = ex_q;
      mem_d = '0;
    end else if (raw) begin
      ex_d  = '0;
    end

    cnt_d = cnt_q;
    if (stall && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.stall_o     = stall;
  assign bus.bubble_o    = raw;
  assign bus.ex_hold_o   = ex_hold;
  assign bus.mem_hold_o  = mem_hold;
  assign bus.cause_o     = cause;
  assign bus.stall_cnt_o = cnt_q;
  assign bus.ex_slot_o   = ex_q;
  assign bus.mem_slot_o  = mem_q;
  assign bus.wb_slot_o   = wb_q;

endmodule

// File: tb/tb_id_stall_ctrl.sv
// Directed bench for id_stall_ctrl: a freeze-point pipeline model checked every
// cycle, plus hand-computed expectations for the key scenarios.
module tb_id_stall_ctrl;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic       valid;
    logic       we;
    logic [4:0] waddr;
    logic       is_load;
    logic       is_mdu;
  } rec_t;

  logic clk_i;
  logic rst_n_i;
  int   errors = 0;
  int   checks = 0;

  id_stall_ctrl_if #(.CNT_W(CNT_W)) bus ();

  id_stall_ctrl #(.CNT_W(CNT_W)) dut (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .bus     (bus)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic rec_t mk(input logic v, input logic we, input logic [4:0] wa,
                              input logic ld, input logic mdu);
    rec_t r;
    r.valid = v; r.we = we; r.waddr = wa; r.is_load = ld; r.is_mdu = mdu;
    return r;
  endfunction

  // Model: stages 0=EX, 1=MEM, 2=WB. "frz" is the deepest stage that cannot
  // advance (-1 means ID only, -2 means nothing blocked).
  rec_t m_pipe [3] = '{default: '0};
  rec_t m_next [3] = '{default: '0};
  int   m_cnt      = 0;
  int   m_cnt_next = 0;

  always @(negedge clk_i) begin : cmp
    int   frz;
    bit   haz;
    logic re [2];
    logic [4:0] ra [2];
    rec_t id_r;
    int   e_cause;
    if (!rst_n_i) begin
      m_pipe     = '{default: '0};
      m_next     = '{default: '0};
      m_cnt      = 0;
      m_cnt_next = 0;
      frz        = -2;
    end else begin
      re[0] = bus.id_re1_i; ra[0] = bus.id_raddr1_i;
      re[1] = bus.id_re2_i; ra[1] = bus.id_raddr2_i;
      haz = 1'b0;
      for (int n = 0; n < 2; n++)
        if (re[n] && ra[n] != 5'd0 && m_pipe[0].valid && m_pipe[0].we && m_pipe[0].waddr == ra[n])
          haz = 1'b1;
      if (m_pipe[1].valid && m_pipe[1].is_load && !bus.mem_ack_i)      frz = 1;
      else if (m_pipe[0].valid && m_pipe[0].is_mdu && !bus.mdu_done_i) frz = 0;
      else if (bus.id_valid_i && haz)                                  frz = -1;
      else                                                             frz = -2;
      id_r = mk(bus.id_valid_i && !bus.flush_i, bus.id_we_i, bus.id_waddr_i,
                bus.id_is_load_i, bus.id_is_mdu_i);
      for (int s = 2; s >= 0; s--) begin
        if (s <= frz)          m_next[s] = m_pipe[s];
        else if (s == frz + 1) m_next[s] = '0;
        else if (s == 0)       m_next[s] = id_r;
        else                   m_next[s] = m_pipe[s-1];
      end
      m_cnt_next = (frz != -2) ? ((m_cnt + 1 > CNT_MAX) ? CNT_MAX : m_cnt + 1) : m_cnt;
    end
    e_cause = (frz == -2) ? 0 : frz + 2;
    chk("model_stall",    32'(bus.stall_o),    32'(frz != -2));
    chk("model_bubble",   32'(bus.bubble_o),   32'(frz == -1));
    chk("model_ex_hold",  32'(bus.ex_hold_o),  32'(frz == 0));
    chk("model_mem_hold", 32'(bus.mem_hold_o), 32'(frz == 1));
    chk("model_cause",    32'(bus.cause_o),    32'(e_cause));
    chk("model_cnt",      32'(bus.stall_cnt_o), 32'(m_cnt));
    chk("model_ex_slot",  32'(bus.ex_slot_o),  32'(m_pipe[0]));
    chk("model_mem_slot", 32'(bus.mem_slot_o), 32'(m_pipe[1]));
    chk("model_wb_slot",  32'(bus.wb_slot_o),  32'(m_pipe[2]));
  end

  always @(posedge clk_i) begin
    if (!rst_n_i) begin
      m_pipe <= '{default: '0};
      m_cnt  <= 0;
    end else begin
      m_pipe <= m_next;
      m_cnt  <= m_cnt_next;
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic nop();
    bus.id_valid_i = 1'b0; bus.id_re1_i = 1'b0; bus.id_re2_i = 1'b0;
    bus.id_raddr1_i = 5'd0; bus.id_raddr2_i = 5'd0; bus.id_we_i = 1'b0;
    bus.id_waddr_i = 5'd0; bus.id_is_load_i = 1'b0; bus.id_is_mdu_i = 1'b0;
  endtask

  task automatic put(input logic re1, input logic [4:0] ra1, input logic re2, input logic [4:0] ra2,
                     input logic we, input logic [4:0] wa, input logic ld, input logic mdu);
    bus.id_valid_i = 1'b1; bus.id_re1_i = re1; bus.id_raddr1_i = ra1;
    bus.id_re2_i = re2; bus.id_raddr2_i = ra2; bus.id_we_i = we;
    bus.id_waddr_i = wa; bus.id_is_load_i = ld; bus.id_is_mdu_i = mdu;
  endtask

  task automatic do_reset();
    rst_n_i = 1'b0;
    nop();
    bus.flush_i = 1'b0; bus.mem_ack_i = 1'b0; bus.mdu_done_i = 1'b0;
    tick();
    rst_n_i = 1'b1;
  endtask

  initial begin
    // Reset held with hazard-looking inputs: everything stays zero.
    rst_n_i = 1'b0;
    bus.flush_i = 1'b0; bus.mem_ack_i = 1'b0; bus.mdu_done_i = 1'b1;
    put(1, 5, 1, 7, 1, 5, 1, 1);
    repeat (2) @(posedge clk_i);
    #3;
    chk("rst_stall", 32'(bus.stall_o), 0);
    chk("rst_cause", 32'(bus.cause_o), 0);
    chk("rst_cnt",   32'(bus.stall_cnt_o), 0);
    chk("rst_ex",    32'(bus.ex_slot_o), 0);

    // ALU producer then dependent consumer.
    do_reset();
    put(1, 1, 1, 2, 1, 5, 0, 0);
    #2 chk("add_nostall", 32'(bus.stall_o), 0);
    tick();
    put(1, 5, 1, 1, 1, 6, 0, 0);
    #2 chk("raw_stall",  32'(bus.stall_o), 1);
    chk("raw_bubble", 32'(bus.bubble_o), 1);
    chk("raw_cause",  32'(bus.cause_o), 1);
    tick();
    #2 chk("raw_clear",   32'(bus.stall_o), 0);
    chk("raw_mem_add", 32'(bus.mem_slot_o), 32'(mk(1, 1, 5, 0, 0)));
    chk("raw_cnt",     32'(bus.stall_cnt_o), 1);
    tick();
    nop();
    #2 chk("sub_in_ex", 32'(bus.ex_slot_o), 32'(mk(1, 1, 6, 0, 0)));
    chk("add_in_wb", 32'(bus.wb_slot_o), 32'(mk(1, 1, 5, 0, 0)));

    // x0 and disabled read ports never hazard.
    do_reset();
    put(0, 0, 0, 0, 1, 0, 0, 0);
    tick();
    put(1, 0, 1, 0, 1, 8, 0, 0);
    #2 chk("x0_nostall", 32'(bus.stall_o), 0);
    tick();
    put(0, 0, 0, 0, 1, 7, 0, 0);
    tick();
    put(0, 7, 1, 2, 1, 9, 0, 0);
    #2 chk("re_off_nostall", 32'(bus.stall_o), 0);
    tick();

    // Load with three cycles of missing ack.
    do_reset();
    put(1, 1, 0, 0, 1, 3, 1, 0);
    tick();
    put(1, 3, 0, 0, 1, 4, 0, 0);
    #2 chk("ld_raw_cause", 32'(bus.cause_o), 1);
    tick();
    for (int i = 0; i < 3; i++) begin
      #2 chk("ld_mem_hold", 32'(bus.mem_hold_o), 1);
      chk("ld_cause3",   32'(bus.cause_o), 3);
      chk("ld_wb_inval", 32'(bus.wb_slot_o[8]), 0);
      tick();
    end
    bus.mem_ack_i = 1'b1;
    #2 chk("ld_ack_free", 32'(bus.stall_o), 0);
    chk("ld_cnt", 32'(bus.stall_cnt_o), 4);
    tick();
    nop();
    tick();

    // DIV completing on its fifth EX cycle.
    do_reset();
    put(1, 1, 1, 2, 1, 9, 0, 1);
    tick();
    nop();
    for (int i = 0; i < 4; i++) begin
      #2 chk("div_ex_hold", 32'(bus.ex_hold_o), 1);
      chk("div_cause2", 32'(bus.cause_o), 2);
      if (i > 0) chk("div_mem_inval", 32'(bus.mem_slot_o[8]), 0);
      tick();
    end
    bus.mdu_done_i = 1'b1;
    #2 chk("div_done_free", 32'(bus.stall_o), 0);
    tick();
    bus.mdu_done_i = 1'b0;
    #2 chk("div_in_mem", 32'(bus.mem_slot_o), 32'(mk(1, 1, 9, 0, 1)));
    tick();

    // Pending load in MEM outranks a busy MDU in EX.
    do_reset();
    put(1, 1, 0, 0, 1, 3, 1, 0);
    tick();
    put(1, 2, 0, 0, 1, 9, 0, 1);
    tick();
    nop();
    #2 chk("both_mem_hold", 32'(bus.mem_hold_o), 1);
    chk("both_ex_hold0", 32'(bus.ex_hold_o), 0);
    chk("both_cause3",   32'(bus.cause_o), 3);
    tick();
    bus.mem_ack_i = 1'b1;
    #2 chk("after_ack_ex_hold", 32'(bus.ex_hold_o), 1);
    chk("after_ack_cause2", 32'(bus.cause_o), 2);
    tick();
    bus.mdu_done_i = 1'b1;
    #2 chk("mdu_release", 32'(bus.stall_o), 0);
    tick();
    bus.mdu_done_i = 1'b0;
    tick();

    // Flush of an independent instruction, then flush during mem_hold.
    do_reset();
    put(1, 1, 1, 2, 1, 4, 0, 0);
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    nop();
    #2 chk("flush_ex_inval", 32'(bus.ex_slot_o[8]), 0);
    put(1, 1, 0, 0, 1, 3, 1, 0);
    tick();
    put(1, 1, 0, 0, 1, 4, 0, 0);
    tick();
    bus.flush_i = 1'b1;
    put(1, 1, 0, 0, 1, 10, 0, 0);
    #2 chk("flush_hold", 32'(bus.mem_hold_o), 1);
    tick();
    #2 chk("flush_hold_ex",  32'(bus.ex_slot_o), 32'(mk(1, 1, 4, 0, 0)));
    chk("flush_hold_mem", 32'(bus.mem_slot_o), 32'(mk(1, 1, 3, 1, 0)));
    bus.mem_ack_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    nop();
    #2 chk("flush_after_ex",  32'(bus.ex_slot_o[8]), 0);
    chk("flush_after_mem", 32'(bus.mem_slot_o), 32'(mk(1, 1, 4, 0, 0)));
    tick();

    // Counter saturation over a long memory wait, then reset mid-stall.
    do_reset();
    put(1, 1, 0, 0, 1, 3, 1, 0);
    tick();
    nop();
    tick();
    repeat (20) tick();
    #2 chk("sat_cnt",   32'(bus.stall_cnt_o), 15);
    chk("sat_stall", 32'(bus.stall_o), 1);
    put(1, 3, 1, 3, 1, 3, 1, 1);
    rst_n_i = 1'b0;
    #1 chk("midrst_stall", 32'(bus.stall_o), 0);
    chk("midrst_hold",  32'(bus.mem_hold_o), 0);
    chk("midrst_cause", 32'(bus.cause_o), 0);
    chk("midrst_cnt",   32'(bus.stall_cnt_o), 0);
    chk("midrst_mem",   32'(bus.mem_slot_o), 0);
    tick();
    rst_n_i = 1'b1;
    nop();
    bus.mem_ack_i = 1'b1;
    #2 chk("restart_stall", 32'(bus.stall_o), 0);
    chk("restart_ex", 32'(bus.ex_slot_o), 0);
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
